// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types for the I2S transmit scheduler and its pair FIFO.
package i2s_pkg;

    localparam int AUDIO_W = 24;

    // One stereo sample pair as stored in the FIFO.
    typedef struct packed {
        logic [AUDIO_W-1:0] left;
        logic [AUDIO_W-1:0] right;
    } stereo_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/i2s_pair_fifo.sv
// i2s_pair_fifo: synchronous FIFO of stereo pairs with registered full/empty/level.
// DEPTH must be a power of two and at least 2.
module i2s_pair_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  stereo_t                wr_data,
    input  logic                   pop,
    output stereo_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    stereo_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;
    logic           full_q, empty_q;
    logic           do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // Pointer and occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + LW'(1);
        else if (!do_push && do_pop) count_d = count_q - LW'(1);
    end

    // Control registers; full/empty are precomputed from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == LW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = count_q;

endmodule

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: buffers stereo pairs, generates bclk/dalrc and issues serializer loads.
// Optional macro UNDERRUN_REPEAT_EN: on underrun re-emit the last popped pair instead of zeros.
// DATA_W must equal AUDIO_W because FIFO entries are stereo_t.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int DATA_W    = AUDIO_W,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4,
    parameter int DEPTH     = 4
) (
    input  logic                   clk_12M,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_left,
    input  logic [DATA_W-1:0]      s_right,
    output logic                   bclk,
    output logic                   dalrc,
    output logic [DATA_W-1:0]      ser_data,
    output logic                   ser_load,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    sched_state_e       state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               bclk_q, bclk_d;
    logic               dalrc_q, dalrc_d;
    logic               ser_load_q, ser_load_d;
    logic               underrun_q, underrun_d;
    logic [DATA_W-1:0]  ser_data_q, ser_data_d;
    logic [DATA_W-1:0]  right_q, right_d;

    stereo_t            fifo_wr, fifo_rd;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_wr.left  = s_left;
    assign fifo_wr.right = s_right;
    assign fifo_push     = s_valid && !fifo_full;

    i2s_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_12M),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

`ifdef UNDERRUN_REPEAT_EN
    stereo_t last_q, last_d;

    // Remember the most recently popped pair so an underrun can repeat it.
    always_comb begin
        last_d = last_q;
        if (fifo_pop) last_d = fifo_rd;
    end

    // Last-pair register, zero until the first pop.
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= last_d;
    end
`endif

    // Next-state, counters and output decode; outputs are registered so they lag the counters by one cycle.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bclk_d     = 1'b0;
        dalrc_d    = 1'b0;
        ser_load_d = 1'b0;
        underrun_d = 1'b0;
        ser_data_d = ser_data_q;
        right_d    = right_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    right_d   = '0;
                end else begin
                    bclk_d  = (div_cnt_q >= DIV_W'(BCLK_DIV / 2));
                    dalrc_d = (bit_cnt_q < BIT_W'(SLOT_BITS));
                    if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
                        div_cnt_d = '0;
                        if (bit_cnt_q == BIT_W'(2 * SLOT_BITS - 1)) bit_cnt_d = '0;
                        else                                         bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                    if (div_cnt_q == '0 && bit_cnt_q == '0) begin
                        ser_load_d = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            ser_data_d = fifo_rd.left;
                            right_d    = fifo_rd.right;
                        end else begin
                            underrun_d = 1'b1;
`ifdef UNDERRUN_REPEAT_EN
                            ser_data_d = last_q.left;
                            right_d    = last_q.right;
`else
                            ser_data_d = '0;
                            right_d    = '0;
`endif
                        end
                    end else if (div_cnt_q == '0 && bit_cnt_q == BIT_W'(SLOT_BITS)) begin
                        ser_load_d = 1'b1;
                        ser_data_d = right_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            dalrc_q    <= 1'b0;
            ser_load_q <= 1'b0;
            underrun_q <= 1'b0;
            ser_data_q <= '0;
            right_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            dalrc_q    <= dalrc_d;
            ser_load_q <= ser_load_d;
            underrun_q <= underrun_d;
            ser_data_q <= ser_data_d;
            right_q    <= right_d;
        end
    end

    assign s_ready  = !fifo_full;
    assign bclk     = bclk_q;
    assign dalrc    = dalrc_q;
    assign ser_load = ser_load_q;
    assign underrun = underrun_q;
    assign ser_data = ser_data_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: directed, table-driven bench for i2s_tx_sched (honours UNDERRUN_REPEAT_EN).
module tb_i2s_tx_sched;

    localparam int DATA_W      = 24;
    localparam int SLOT_BITS   = 32;
    localparam int BCLK_DIV    = 4;
    localparam int DEPTH       = 4;
    localparam int LOAD_PERIOD = SLOT_BITS * BCLK_DIV;

    logic              clk_12M = 1'b0;
    logic              rst_n   = 1'b0;
    logic              en      = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_left  = '0;
    logic [DATA_W-1:0] s_right = '0;
    logic              s_ready;
    logic              bclk;
    logic              dalrc;
    logic [DATA_W-1:0] ser_data;
    logic              ser_load;
    logic              underrun;
    logic [2:0]        level;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] in_left;
        logic [23:0] in_right;
        logic [2:0]  exp_level;
        logic        exp_ready;
        logic [23:0] exp_left;
        logic [23:0] exp_right;
        logic        exp_underrun;
    } vec_t;

    vec_t vecs [5];

    i2s_tx_sched #(
        .DATA_W    (DATA_W),
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_12M  (clk_12M),
        .rst_n    (rst_n),
        .en       (en),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .dalrc    (dalrc),
        .ser_data (ser_data),
        .ser_load (ser_load),
        .underrun (underrun),
        .level    (level)
    );

    always #5 clk_12M = ~clk_12M;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Push one pair; called at a negedge, returns at the following negedge.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(negedge clk_12M);
        s_valid = 1'b0;
    endtask

    // Step negedges until ser_load is seen or the budget runs out.
    task automatic waitLoad(input int budget, output int cycles);
        cycles = 0;
        @(negedge clk_12M);
        cycles = 1;
        while (ser_load !== 1'b1 && cycles < budget) begin
            @(negedge clk_12M);
            cycles++;
        end
        if (ser_load !== 1'b1) checkOutput("load_timeout", 32'(ser_load), 32'd1);
    endtask

    // Walk the rest of a slot after a load and tally bclk/dalrc/ser_load deviations.
    task automatic checkSlot(input logic exp_dalrc, input string tag);
        int bclk_err  = 0;
        int dalrc_err = 0;
        int load_err  = 0;
        for (int k = 1; k < LOAD_PERIOD; k++) begin
            logic exp_b;
            @(negedge clk_12M);
            exp_b = ((k % BCLK_DIV) >= (BCLK_DIV / 2));
            if (bclk !== exp_b)      bclk_err++;
            if (dalrc !== exp_dalrc) dalrc_err++;
            if (ser_load !== 1'b0)   load_err++;
        end
        checkOutput({tag, "_bclk_pattern"},  32'(bclk_err),  32'd0);
        checkOutput({tag, "_dalrc_level"},   32'(dalrc_err), 32'd0);
        checkOutput({tag, "_no_extra_load"}, 32'(load_err),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int cnt;

        vecs[0] = '{24'h100001, 24'h200001, 3'd1, 1'b1, 24'h100001, 24'h200001, 1'b0};
        vecs[1] = '{24'h100002, 24'h200002, 3'd2, 1'b1, 24'h100002, 24'h200002, 1'b0};
        vecs[2] = '{24'h100003, 24'h200003, 3'd3, 1'b1, 24'h100003, 24'h200003, 1'b0};
        vecs[3] = '{24'h111111, 24'h222222, 3'd4, 1'b0, 24'h111111, 24'h222222, 1'b0};
`ifdef UNDERRUN_REPEAT_EN
        vecs[4] = '{24'h1BAD01, 24'h2BAD01, 3'd4, 1'b0, 24'h111111, 24'h222222, 1'b1};
`else
        vecs[4] = '{24'h1BAD01, 24'h2BAD01, 3'd4, 1'b0, 24'h000000, 24'h000000, 1'b1};
`endif

        $display("[TB] reset values");
        repeat (5) @(negedge clk_12M);
        checkOutput("rst_bclk",     32'(bclk),     32'd0);
        checkOutput("rst_dalrc",    32'(dalrc),    32'd0);
        checkOutput("rst_ser_load", 32'(ser_load), 32'd0);
        checkOutput("rst_s_ready",  32'(s_ready),  32'd1);
        checkOutput("rst_level",    32'(level),    32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_ser_data", 32'(ser_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_12M);

        $display("[TB] single pair, timing and underrun");
        applyStimulus(24'hA5A5A5, 24'hA12345);
        checkOutput("p1_level", 32'(level), 32'd1);
        en = 1'b1;
        waitLoad(300, c);
        checkOutput("p1_first_latency", 32'(c),        32'd2);
        checkOutput("p1_left_data",     32'(ser_data), 32'hA5A5A5);
        checkOutput("p1_left_dalrc",    32'(dalrc),    32'd1);
        checkOutput("p1_left_underrun", 32'(underrun), 32'd0);
        checkOutput("p1_level_popped",  32'(level),    32'd0);
        checkSlot(1'b1, "p1_left");
        waitLoad(300, c);
        checkOutput("p1_right_period", 32'(c),        32'd1);
        checkOutput("p1_right_data",   32'(ser_data), 32'hA12345);
        checkOutput("p1_right_dalrc",  32'(dalrc),    32'd0);
        checkSlot(1'b0, "p1_right");
        waitLoad(300, c);
        checkOutput("ur_period",   32'(c),        32'd1);
        checkOutput("ur_pulse",    32'(underrun), 32'd1);
        checkOutput("ur_dalrc",    32'(dalrc),    32'd1);
`ifdef UNDERRUN_REPEAT_EN
        checkOutput("ur_left_data", 32'(ser_data), 32'hA5A5A5);
`else
        checkOutput("ur_left_data", 32'(ser_data), 32'd0);
`endif
        @(negedge clk_12M);
        checkOutput("ur_pulse_width", 32'(underrun), 32'd0);
        waitLoad(300, c);
`ifdef UNDERRUN_REPEAT_EN
        checkOutput("ur_right_data", 32'(ser_data), 32'hA12345);
`else
        checkOutput("ur_right_data", 32'(ser_data), 32'd0);
`endif
        en = 1'b0;
        @(negedge clk_12M);
        checkOutput("stop_bclk",  32'(bclk),  32'd0);
        checkOutput("stop_dalrc", 32'(dalrc), 32'd0);
        @(negedge clk_12M);

        $display("[TB] fill FIFO from table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].in_left, vecs[i].in_right);
            checkOutput($sformatf("fill%0d_level", i), 32'(level),   32'(vecs[i].exp_level));
            checkOutput($sformatf("fill%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitLoad(300, c);
            checkOutput($sformatf("emit%0d_left", i),     32'(ser_data), 32'(vecs[i].exp_left));
            checkOutput($sformatf("emit%0d_ldalrc", i),   32'(dalrc),    32'd1);
            checkOutput($sformatf("emit%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_underrun));
            if (i == 0) begin
                checkOutput("emit0_latency", 32'(c),       32'd2);
                checkOutput("emit0_ready",   32'(s_ready), 32'd1);
                checkOutput("emit0_level",   32'(level),   32'd3);
            end
            waitLoad(300, c);
            checkOutput($sformatf("emit%0d_right", i),  32'(ser_data), 32'(vecs[i].exp_right));
            checkOutput($sformatf("emit%0d_rdalrc", i), 32'(dalrc),    32'd0);
        end
        cnt = 0;
        for (int k = 0; k < 2 * LOAD_PERIOD; k++) begin
            @(negedge clk_12M);
            if (underrun === 1'b1) cnt++;
        end
        checkOutput("ur_once_per_frame", 32'(cnt), 32'd1);
        en = 1'b0;
        repeat (2) @(negedge clk_12M);

        $display("[TB] en drop mid-frame");
        applyStimulus(24'h0ABCDE, 24'h0FEDCB);
        applyStimulus(24'h135790, 24'h246800);
        en = 1'b1;
        waitLoad(300, c);
        checkOutput("drop_p1_left", 32'(ser_data), 32'h0ABCDE);
        checkOutput("drop_level",   32'(level),    32'd1);
        repeat (39) @(negedge clk_12M);
        checkOutput("drop_pre_bclk",  32'(bclk),  32'd1);
        checkOutput("drop_pre_dalrc", 32'(dalrc), 32'd1);
        en = 1'b0;
        @(negedge clk_12M);
        checkOutput("drop_post_bclk",  32'(bclk),  32'd0);
        checkOutput("drop_post_dalrc", 32'(dalrc), 32'd0);
        checkOutput("drop_post_level", 32'(level), 32'd1);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_12M);
            if (ser_load === 1'b1) cnt++;
        end
        checkOutput("drop_no_loads", 32'(cnt), 32'd0);
        en = 1'b1;
        waitLoad(300, c);
        checkOutput("reen_latency",  32'(c),        32'd2);
        checkOutput("reen_dalrc",    32'(dalrc),    32'd1);
        checkOutput("reen_left",     32'(ser_data), 32'h135790);
        checkOutput("reen_level",    32'(level),    32'd0);
        checkOutput("reen_underrun", 32'(underrun), 32'd0);
        waitLoad(300, c);
        checkOutput("reen_right", 32'(ser_data), 32'h246800);

        $display("[TB] reset mid-run");
        applyStimulus(24'h314159, 24'h271828);
        applyStimulus(24'h161803, 24'h141421);
        waitLoad(300, c);
        checkOutput("mid_left",  32'(ser_data), 32'h314159);
        checkOutput("mid_level", 32'(level),    32'd1);
        repeat (2) @(negedge clk_12M);
        checkOutput("mid_pre_bclk", 32'(bclk), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_bclk",     32'(bclk),     32'd0);
        checkOutput("mid_rst_dalrc",    32'(dalrc),    32'd0);
        checkOutput("mid_rst_ser_load", 32'(ser_load), 32'd0);
        checkOutput("mid_rst_s_ready",  32'(s_ready),  32'd1);
        checkOutput("mid_rst_level",    32'(level),    32'd0);
        checkOutput("mid_rst_ser_data", 32'(ser_data), 32'd0);
        @(negedge clk_12M);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_12M);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
